// File: rtl/seven_seg_reader.sv
// Reads back four active-low seven-segment digits, waits for STABLE_CYCLES identical samples,
// then latches the decoded values with a one-cycle o_valid strobe. Optional sum check: SEVEN_SEG_READER_CHECK_EN.
module seven_seg_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_hex0,
  input  logic [6:0] i_hex1,
  input  logic [6:0] i_hex2,
  input  logic [6:0] i_hex3,
  output logic [3:0] o_a,
  output logic [3:0] o_b,
  output logic [4:0] o_sum,
  output logic       o_valid,
  output logic       o_err,
  output logic       o_mismatch
);

  localparam int CNT_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [3:0] value;
  } digit_t;

  localparam logic [6:0] SEG_ZERO = 7'b1000000;
  localparam logic [6:0] SEG_ONE  = 7'b1111001;

  // Full hex decode; anything outside the table is illegal and reads as zero.
  function automatic digit_t decode_digit(input logic [6:0] seg);
    digit_t d;
    d = '0;
    case (seg)
      7'b1000000: d = '{1'b1, 4'h0};
      7'b1111001: d = '{1'b1, 4'h1};
      7'b0100100: d = '{1'b1, 4'h2};
      7'b0110000: d = '{1'b1, 4'h3};
      7'b0011001: d = '{1'b1, 4'h4};
      7'b0010010: d = '{1'b1, 4'h5};
      7'b0000010: d = '{1'b1, 4'h6};
      7'b1111000: d = '{1'b1, 4'h7};
      7'b0000000: d = '{1'b1, 4'h8};
      7'b0010000: d = '{1'b1, 4'h9};
      7'b0001000: d = '{1'b1, 4'hA};
      7'b0000011: d = '{1'b1, 4'hB};
      7'b1000110: d = '{1'b1, 4'hC};
      7'b0100001: d = '{1'b1, 4'hD};
      7'b0000110: d = '{1'b1, 4'hE};
      7'b0001110: d = '{1'b1, 4'hF};
      default:    d = '0;
    endcase
    return d;
  endfunction

  state_t           state, state_next;
  logic [27:0]      r_snap;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [27:0]      sample;
  logic             changed;
  logic             full;
  logic             latch;

  digit_t     dig_a;
  digit_t     dig_b;
  digit_t     dig_s;
  logic       h3_legal;
  logic       h3_one;
  logic [4:0] sum_now;
  logic       err_now;

  assign sample = {i_hex3, i_hex2, i_hex1, i_hex0};

  assign dig_a    = decode_digit(i_hex0);
  assign dig_b    = decode_digit(i_hex1);
  assign dig_s    = decode_digit(i_hex2);
  assign h3_one   = (i_hex3 == SEG_ONE);
  assign h3_legal = h3_one || (i_hex3 == SEG_ZERO);
  assign sum_now  = {h3_one, dig_s.value};
  assign err_now  = !dig_a.legal || !dig_b.legal || !dig_s.legal || !h3_legal;

  // Stability counter and latch decision. IDLE always treats the sample as new data.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_next = state;
    latch      = 1'b0;
    changed    = (sample != r_snap) || (state == IDLE);
    if (changed) begin
      cnt_next = CNT_ONE;
    end else if (r_cnt >= CNT_MAX) begin
      cnt_next = CNT_MAX;
    end else begin
      cnt_next = r_cnt + CNT_ONE;
    end
    full = (cnt_next == CNT_MAX);

    case (state)
      IDLE: begin
        state_next = full ? LOCKED : SETTLE;
        latch      = full;
      end
      SETTLE: begin
        if (full) begin
          state_next = LOCKED;
          latch      = 1'b1;
        end
      end
      LOCKED: begin
        // With STABLE_CYCLES = 1 a change re-latches without leaving LOCKED.
        if (changed) begin
          state_next = full ? LOCKED : SETTLE;
          latch      = full;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (i_rst) begin
      state   <= IDLE;
      r_snap  <= '1;
      r_cnt   <= '0;
      o_a     <= '0;
      o_b     <= '0;
      o_sum   <= '0;
      o_err   <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      state   <= state_next;
      // Unconditional load: when the sample is unchanged it already equals r_snap.
      r_snap  <= sample;
      r_cnt   <= cnt_next;
      o_valid <= latch;
      if (latch) begin
        o_a   <= dig_a.value;
        o_b   <= dig_b.value;
        o_sum <= sum_now;
        o_err <= err_now;
      end
    end
  end

`ifdef SEVEN_SEG_READER_CHECK_EN
  logic [4:0] ab_sum;
  assign ab_sum = {1'b0, dig_a.value} + {1'b0, dig_b.value};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_mismatch <= 1'b0;
    end else if (latch) begin
      o_mismatch <= (ab_sum != sum_now);
    end
  end
`else
  assign o_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_seven_seg_reader.sv
// Self-checking bench for seven_seg_reader: directed table, multi-cycle corner sequences,
// and random stimulus against a run-length reference model for STABLE_CYCLES = 4 and 1.
module tb_seven_seg_reader;

`ifdef SEVEN_SEG_READER_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] h0, h1, h2, h3;

  logic [3:0] a4, b4, a1, b1;
  logic [4:0] sum4, sum1;
  logic       v4, e4, m4, v1, e1, m1;

  always #5 clk = ~clk;

  seven_seg_reader dut4 (
    .i_clk(clk), .i_rst(rst),
    .i_hex0(h0), .i_hex1(h1), .i_hex2(h2), .i_hex3(h3),
    .o_a(a4), .o_b(b4), .o_sum(sum4),
    .o_valid(v4), .o_err(e4), .o_mismatch(m4)
  );

  seven_seg_reader #(.STABLE_CYCLES(1)) dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_hex0(h0), .i_hex1(h1), .i_hex2(h2), .i_hex3(h3),
    .o_a(a1), .o_b(b1), .o_sum(sum1),
    .o_valid(v1), .o_err(e1), .o_mismatch(m1)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Value -> active-low segment pattern.
  function automatic logic [6:0] enc(input int v);
    case (v)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;  6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000; 10: return 7'b0001000; 11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  // Pattern -> value by searching the encoder; -1 when illegal.
  function automatic int dec(input logic [6:0] p, input int limit);
    for (int v = 0; v < limit; v++) if (enc(v) == p) return v;
    return -1;
  endfunction

  // Expected latched fields {a[14:11], b[10:7], sum[6:2], err[1], mm[0]}.
  function automatic logic [14:0] expect_fields(input logic [6:0] p0, p1, p2, p3);
    int va, vb, vs, vh, total;
    logic err;
    va = dec(p0, 16); vb = dec(p1, 16); vs = dec(p2, 16); vh = dec(p3, 2);
    err = (va < 0) || (vb < 0) || (vs < 0) || (vh < 0);
    if (va < 0) va = 0;
    if (vb < 0) vb = 0;
    if (vs < 0) vs = 0;
    if (vh < 0) vh = 0;
    total = vh * 16 + vs;
    return {va[3:0], vb[3:0], total[4:0], err, CHECK_EN && ((va + vb) != total)};
  endfunction

  // Reference model: length of the current run of identical samples, one latch per run.
  logic [27:0] m_prev  [2];
  bit          m_have  [2];
  int          m_run   [2];
  bit          m_fired [2];
  logic [15:0] m_out   [2];

  task automatic model_edge(input int idx, input int s);
    logic [27:0] cur;
    cur = {h3, h2, h1, h0};
    if (rst) begin
      m_have[idx] = 1'b0; m_run[idx] = 0; m_fired[idx] = 1'b0; m_out[idx] = '0;
    end else begin
      if (!m_have[idx] || cur != m_prev[idx]) begin
        m_run[idx] = 1; m_fired[idx] = 1'b0;
      end else begin
        m_run[idx]++;
      end
      m_prev[idx] = cur;
      m_have[idx] = 1'b1;
      if (m_run[idx] >= s && !m_fired[idx]) begin
        m_fired[idx] = 1'b1;
        m_out[idx]   = {1'b1, expect_fields(h0, h1, h2, h3)};
      end else begin
        m_out[idx][15] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0, 4);
    model_edge(1, 1);
    #1;
    check("scb_s4", {v4, a4, b4, sum4, e4, m4}, m_out[0]);
    check("scb_s1", {v1, a1, b1, sum1, e1, m1}, m_out[1]);
  endtask

  task automatic set_in(input logic [6:0] p0, p1, p2, p3);
    h0 = p0; h1 = p1; h2 = p2; h3 = p3;
  endtask

  typedef struct {
    logic [6:0] p0, p1, p2, p3;
    logic [3:0] a, b;
    logic [4:0] sum;
    logic       err;
    logic       mm_en;
  } vec_t;

  vec_t vecs[8];
  int   pulses;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{enc(3), enc(2), enc(5), enc(0), 4'd3, 4'd2, 5'd5, 1'b0, 1'b0};
    vecs[1] = '{enc(8), enc(8), enc(0), enc(1), 4'd8, 4'd8, 5'd16, 1'b0, 1'b0};
    vecs[2] = '{7'b1111111, enc(0), enc(0), enc(0), 4'd0, 4'd0, 5'd0, 1'b1, 1'b0};
    vecs[3] = '{enc(0), enc(0), enc(0), enc(2), 4'd0, 4'd0, 5'd0, 1'b1, 1'b0};
    vecs[4] = '{enc(15), enc(15), enc(14), enc(0), 4'd15, 4'd15, 5'd14, 1'b0, 1'b1};
    vecs[5] = '{enc(7), enc(1), enc(8), enc(0), 4'd7, 4'd1, 5'd8, 1'b0, 1'b0};
    vecs[6] = '{enc(9), enc(9), enc(2), enc(1), 4'd9, 4'd9, 5'd18, 1'b0, 1'b0};
    vecs[7] = '{enc(10), enc(11), enc(5), enc(1), 4'd10, 4'd11, 5'd21, 1'b0, 1'b0};
    for (int i = 0; i < 2; i++) begin
      m_prev[i] = '0; m_have[i] = 1'b0; m_run[i] = 0; m_fired[i] = 1'b0; m_out[i] = '0;
    end

    rst = 1'b1;
    set_in('1, '1, '1, '1);
    step();
    step();
    check("reset_s4", {v4, a4, b4, sum4, e4, m4}, 16'h0);
    check("reset_s1", {v1, a1, b1, sum1, e1, m1}, 16'h0);

    // Directed table: reset, hold, latch on the 4th sample only.
    foreach (vecs[i]) begin
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_in(vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].p3);
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
        step();
        pulses += int'(v4);
      end
      check($sformatf("vec%0d_early", i), pulses, 0);
      step();
      check($sformatf("vec%0d_valid", i), v4, 1'b1);
      check($sformatf("vec%0d_out", i), {a4, b4, sum4, e4, m4},
            {vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].err, CHECK_EN & vecs[i].mm_en});
      step();
      check($sformatf("vec%0d_drop", i), v4, 1'b0);
      if (i == 1) begin
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
          step();
          pulses += int'(v4);
        end
        check("hold_no_repulse", pulses, 0);
      end
    end

    // Glitch: 7/1/8/0, hex0 -> 0 after two samples, back to 7 one cycle later.
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_in(enc(7), enc(1), enc(8), enc(0));
    pulses = 0;
    step(); pulses += int'(v4);
    step(); pulses += int'(v4);
    h0 = enc(0);
    step(); pulses += int'(v4);
    h0 = enc(7);
    for (int k = 0; k < 3; k++) begin
      step();
      pulses += int'(v4);
    end
    check("glitch_no_early", pulses, 0);
    step();
    check("glitch_valid", v4, 1'b1);
    check("glitch_out", {a4, b4, sum4}, {4'd7, 4'd1, 5'd8});

    // Change away and back to the latched value: re-latch with a fresh pulse.
    h0 = enc(3);
    step();
    h0 = enc(7);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      pulses += int'(v4);
    end
    check("relatch_no_early", pulses, 0);
    step();
    check("relatch_valid", v4, 1'b1);

    // Reset two cycles into SETTLE discards the pending latch.
    set_in(enc(3), enc(2), enc(5), enc(0));
    step();
    step();
    rst = 1'b1;
    step();
    check("rst_settle", {v4, a4, b4, sum4, e4, m4}, 16'h0);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      pulses += int'(v4);
    end
    check("rst_settle_full_count", pulses, 0);
    step();
    check("rst_settle_latch", {v4, a4, b4, sum4}, {1'b1, 4'd3, 4'd2, 5'd5});

    // Reset during the valid pulse.
    rst = 1'b1;
    step();
    check("rst_pulse", {v4, a4, b4, sum4, e4, m4}, 16'h0);
    rst = 1'b0;

    // STABLE_CYCLES = 1: a new value every cycle strobes every cycle.
    for (int k = 0; k < 3; k++) begin
      set_in(enc(k + 4), enc(k), enc(k + 4), enc(0));
      step();
      check($sformatf("s1_stream%0d", k), {v1, a1}, {1'b1, 4'(k + 4)});
    end
    step();
    check("s1_hold_drop", v1, 1'b0);

    // Random stimulus: mostly holds, digit changes, occasional illegal codes and resets.
    for (int n = 0; n < 3000; n++) begin
      int r, which;
      logic [6:0] pat;
      r   = $urandom_range(0, 99);
      rst = (r < 2);
      if (r >= 2 && r < 27) begin
        which = $urandom_range(0, 3);
        if ($urandom_range(0, 9) == 0) pat = 7'($urandom);
        else if (which == 3)           pat = enc($urandom_range(0, 1));
        else                           pat = enc($urandom_range(0, 15));
        case (which)
          0:       h0 = pat;
          1:       h1 = pat;
          2:       h2 = pat;
          default: h3 = pat;
        endcase
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
